score_display_driver: RTL and testbench

//   Display end of the scoreboard counter value bus. Converts a BW-bit binary score
//   (0-99) into two BCD digits with a sequential shift-add-3 (double-dabble) FSM.

---
 rtl/score_display_driver.sv | 152 +++++++++++++++
 tb/tb_score_display_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - binary score to multiplexed two-digit 7-segment driver (option: LEADING_ZERO_BLANK_EN)
module score_display_driver #(
    parameter int BW          = 7,
    parameter int MAX_VAL     = 99,
    parameter int REFRESH_DIV = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          busy_o
);

    localparam int IW = $clog2(BW + 1);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] v_clamp;
    logic [BW-1:0] last_q;
    logic [BW-1:0] cap_q;
    logic [BW-1:0] shreg_q;
    logic [7:0]    scratch_q;
    logic [IW-1:0] iter_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic [7:0]    adj;
    logic [BW+7:0] work;
    logic [CW-1:0] cnt_q;
    logic          slot_q;
    logic          slot_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Values above the limit are shown saturated, so hundreds never appear.
    assign v_clamp = (value_i > BW'(MAX_VAL)) ? BW'(MAX_VAL) : value_i;
    assign busy_o  = (state_q != IDLE);

    // Conversion state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start on a new value, run BW shifts, then one commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (v_clamp != last_q) state_d = SHIFT;
            SHIFT:   if (iter_q == IW'(BW - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift left by one.
    always_comb begin
        adj = scratch_q;
        if (scratch_q[3:0] >= 4'd5) adj[3:0] = scratch_q[3:0] + 4'd3;
        if (scratch_q[7:4] >= 4'd5) adj[7:4] = scratch_q[7:4] + 4'd3;
        work = {adj, shreg_q} << 1;
    end

    // Conversion datapath; displayed digits only change on the commit cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q    <= '0;
            cap_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_clamp != last_q) begin
                        shreg_q   <= v_clamp;
                        cap_q     <= v_clamp;
                        scratch_q <= '0;
                        iter_q    <= '0;
                    end
                end
                SHIFT: begin
                    scratch_q <= work[BW+7:BW];
                    shreg_q   <= work[BW-1:0];
                    iter_q    <= iter_q + IW'(1);
                end
                DONE: begin
                    tens_q <= scratch_q[7:4];
                    ones_q <= scratch_q[3:0];
                    last_q <= cap_q;
                end
                default: ;
            endcase
        end
    end

    // Slot for the next cycle and the segment pattern that goes with it.
    always_comb begin
        slot_d = slot_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) slot_d = ~slot_q;
        seg_d = slot_d ? seg_decode(tens_q) : seg_decode(ones_q);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot_d && (tens_q == 4'd0)) seg_d = 7'h00;
`endif
    end

    // Free-running digit multiplexer; segments and digit select move together.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            slot_q    <= 1'b0;
            seg_o     <= 7'h3F;
            dig_sel_o <= 2'b01;
        end else begin
            if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            slot_q    <= slot_d;
            seg_o     <= seg_d;
            dig_sel_o <= slot_d ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - scoreboard bench for score_display_driver
module tb_score_display_driver;

    localparam int BW  = 7;
    localparam int DIV = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [BW-1:0] value_i;
    logic [6:0]    seg_o;
    logic [1:0]    dig_sel_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int model_last = 0;

    score_display_driver #(.BW(BW), .MAX_VAL(99), .REFRESH_DIV(DIV)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .value_i   (value_i),
        .seg_o     (seg_o),
        .dig_sel_o (dig_sel_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] tens_seg(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        if (v / 10 == 0) return 7'h00;
`endif
        return seg_of(v / 10);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive a new score; a conversion is expected whenever the clamped value changes.
    task automatic apply(input int v);
        int cv;
        value_i = BW'(v);
        cv = (v > 99) ? 99 : v;
        if (cv != model_last) begin
            exp_q.push_back(cv);
            model_last = cv;
        end
    endtask

    task automatic wait_done();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 12; i++) begin
            @(negedge clk_i);
            quiet = busy_o ? 0 : quiet + 1;
        end
        if (quiet < 12) check("wait_done_timeout", 0, 1);
    endtask

    // Monitor: on each commit pop the expected value, then check both digit slots.
    int cur = 0;
    int chk = 0;
    int busy_len = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_busy = 1'b0;
            busy_len  = 0;
            chk       = 0;
        end else begin
            if (busy_o) busy_len++;
            if (chk > 0) begin
                if (dig_sel_o == 2'b01) check("seg_ones", seg_o, seg_of(cur % 10));
                else if (dig_sel_o == 2'b10) check("seg_tens", seg_o, tens_seg(cur));
                else check("dig_sel_onehot", dig_sel_o, 1);
                chk--;
            end
            if (prev_busy && !busy_o) begin
                check("busy_len", busy_len, BW + 1);
                busy_len = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk = 2 * DIV;
                end
            end
            prev_busy = busy_o;
        end
    end

    initial begin
        rst_i   = 1'b0;
        value_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_seg", seg_o, 7'h3F);
        check("rst_dig_sel", dig_sel_o, 2'b01);
        check("rst_busy", busy_o, 0);
        repeat (3) @(negedge clk_i);
        check("first_wrap_dig_sel", dig_sel_o, 2'b10);
        check("first_wrap_seg", seg_o, tens_seg(0));

        @(negedge clk_i); apply(42);  wait_done();
        @(negedge clk_i); apply(120); wait_done();
        @(negedge clk_i); apply(5);   wait_done();

        @(negedge clk_i); apply(42);
        repeat (2) @(negedge clk_i);
        apply(17);
        wait_done();

        @(negedge clk_i); apply(42);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_busy", busy_o, 0);
        check("abort_seg", seg_o, 7'h3F);
        check("abort_dig_sel", dig_sel_o, 2'b01);
        exp_q.delete();
        model_last = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        apply(int'(value_i));
        wait_done();

        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            apply(int'($urandom_range(0, 127)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 6)) @(negedge clk_i);
                apply(int'($urandom_range(0, 127)));
            end
            wait_done();
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
